tunnel_game_renderer: RTL and testbench
=======================================

TUNNEL_GAME_RENDERER -- requirements
Module: tunnel_game_renderer

Interface
REQ-001 Parameter SCREEN_W, default 640, visible columns; Pixel_column beyond SCREEN_W-1 never draws.
REQ-002 Parameter SPRITE_SIZE, default 6, bot square side in pixels (1..32).
REQ-003 Parameter BOT_X0, default 256, bot reset/restart column.
REQ-004 Parameter BOT_Y, default 256, fixed bot top row.
REQ-005 Parameter STEP, default 1, bot columns moved per frame.
REQ-006 Parameter WALL_X0, default 192, left-wall reset/restart column.
REQ-007 Parameter TUNNEL_W, default 128, distance from left-wall column to right-wall column.
REQ-008 Parameter WALL_THICK, default 1, wall thickness in columns (1..16).
REQ-009 Parameter DRIFT_STEP, default 1, wall columns moved per frame.
REQ-010 clock  in  1  25 MHz pixel clock, sole clock.
REQ-011 rst  in  1  synchronous, active-high reset.
REQ-012 game_info_reg  in  8  [0] left, [1] right, [3:2] drift (01 right, 10 left, else hold), [7] start.
REQ-013 Pixel_row  in  10  current pixel row.
REQ-014 Pixel_column  in  10  current pixel column.
REQ-015 icon  out  2  bot colour: 00 transparent, 11 normal, 01 crashed.
REQ-016 wall  out  2  wall colour: 00 transparent, 10 wall.
REQ-017 collision  out  1  high while in CRASH.
REQ-018 game_state  out  2  00 IDLE, 01 PLAY, 10 CRASH.

Function
REQ-019 Frame start (FS) is the cycle with Pixel_row==0 and Pixel_column==0; all state, position and drift updates occur only at FS.
REQ-020 FSM: IDLE->PLAY at FS when [7]=1; PLAY->CRASH at FS when crash_pending=1; CRASH->IDLE at FS when [7]=0; otherwise hold.
REQ-021 In PLAY at FS: locX -= STEP if [0]=1,[1]=0; locX += STEP if [1]=1,[0]=0; hold if both or neither.
REQ-022 locX saturates to [0, SCREEN_W-SPRITE_SIZE]; no wrap-around.
REQ-023 In PLAY at FS: wallX moves by DRIFT_STEP per [3:2]; saturates to [0, SCREEN_W-TUNNEL_W-WALL_THICK].
REQ-024 locX and wallX are frozen in IDLE and CRASH; CRASH->IDLE reloads BOT_X0 and WALL_X0.
REQ-025 Bot hit: BOT_Y <= row <= BOT_Y+SPRITE_SIZE-1 and locX <= col <= locX+SPRITE_SIZE-1, inclusive, exactly SPRITE_SIZE pixels per axis.
REQ-026 Wall hit: col in [wallX, wallX+WALL_THICK-1] or [wallX+TUNNEL_W, wallX+TUNNEL_W+WALL_THICK-1], any row.
REQ-027 icon and wall are registered, one clock latency from pixel address; icon=01 on bot hit in CRASH, 11 otherwise on hit, else 00.
REQ-028 Comparisons use 11-bit unsigned arithmetic so that edge sums never overflow 10 bits.
REQ-029 crash_pending sets on any cycle in PLAY with simultaneous bot hit and wall hit; it clears at FS, except that a hit on the FS cycle itself sets it for the new frame.
REQ-030 Position updates at FS apply to the frame beginning at that FS; the FS pixel itself is drawn with pre-update positions.

Reset
REQ-031 On rst: game_state=IDLE, locX=BOT_X0, wallX=WALL_X0, crash_pending=0, icon=00, wall=00, collision=0.
REQ-032 rst mid-frame or mid-CRASH takes effect on the next edge and overrides FS updates in the same cycle.

Configuration
REQ-033 With COLLISION_DETECT_EN defined, REQ-029 applies and PLAY->CRASH is reachable.
REQ-034 Without COLLISION_DETECT_EN, crash_pending is tied to 0, CRASH is unreachable, collision is constant 0, and icon never outputs 01.

Verification
REQ-035 Reset then 3 frames with [7]=0, [0]=1 -> state 00, locX stays 256, icon=11 at row 256..261, col 256..261 only.
REQ-036 [7]=1 then [0]=1 for 300 frames -> state 01, locX decrements 1/frame and saturates at 0.
REQ-037 [1]=1, [3:2]=01, SPRITE_SIZE=6 -> locX saturates at 634, wallX saturates at 511; wall=10 at cols 511 and 639.
REQ-038 Drive bot into left wall (wallX=250, locX reaches 250) -> collision=1 and state=10 at next FS; icon=01 over the bot.
REQ-039 In CRASH, [7]=0 -> IDLE at FS, locX=256, wallX=192; [7]=1 -> PLAY at next FS.
REQ-040 Assert rst at row 100 in CRASH -> next cycle all outputs at REQ-031 values; build without COLLISION_DETECT_EN repeats REQ-038 with collision=0.

Source files
------------

// File: rtl/tunnel_game_renderer.sv
// Tunnel game renderer: bot/wall position state machine plus registered per-pixel colour lookup.
// Optional collision logic is enabled by defining COLLISION_DETECT_EN.
module tunnel_game_renderer #(
    parameter int SCREEN_W    = 640,
    parameter int SPRITE_SIZE = 6,
    parameter int BOT_X0      = 256,
    parameter int BOT_Y       = 256,
    parameter int STEP        = 1,
    parameter int WALL_X0     = 192,
    parameter int TUNNEL_W    = 128,
    parameter int WALL_THICK  = 1,
    parameter int DRIFT_STEP  = 1
) (
    input  logic       clock,
    input  logic       rst,
    input  logic [7:0] game_info_reg,
    input  logic [9:0] Pixel_row,
    input  logic [9:0] Pixel_column,
    output logic [1:0] icon,
    output logic [1:0] wall,
    output logic       collision,
    output logic [1:0] game_state
);

    localparam logic [1:0] S_IDLE  = 2'b00;
    localparam logic [1:0] S_PLAY  = 2'b01;
    localparam logic [1:0] S_CRASH = 2'b10;

    localparam logic [10:0] SCR_W    = 11'(SCREEN_W);
    localparam logic [10:0] SPR      = 11'(SPRITE_SIZE);
    localparam logic [10:0] BOT_Y11  = 11'(BOT_Y);
    localparam logic [10:0] STEP11   = 11'(STEP);
    localparam logic [10:0] DRIFT11  = 11'(DRIFT_STEP);
    localparam logic [10:0] TUN_W    = 11'(TUNNEL_W);
    localparam logic [10:0] THICK    = 11'(WALL_THICK);
    localparam logic [10:0] LOC_MAX  = 11'(SCREEN_W - SPRITE_SIZE);
    localparam logic [10:0] WALL_MAX = 11'(SCREEN_W - TUNNEL_W - WALL_THICK);

    logic [1:0]  state;
    logic [10:0] loc_x, wall_x, loc_next, wall_next;
    logic [10:0] row, col;
    logic        fs, bot_hit, wall_hit, crash_pending;
    logic        go_left, go_right, start;
    logic        unused_bits;

    assign row      = {1'b0, Pixel_row};
    assign col      = {1'b0, Pixel_column};
    assign fs       = (Pixel_row == 10'd0) && (Pixel_column == 10'd0);
    assign go_left  = game_info_reg[0];
    assign go_right = game_info_reg[1];
    assign start    = game_info_reg[7];
    assign unused_bits = ^game_info_reg[6:4];
    assign game_state  = state;

    // 11-bit edge sums so loc_x+SPR or wall_x+TUN_W+THICK cannot wrap past 1023
    assign bot_hit = (col < SCR_W) &&
                     (row >= BOT_Y11) && (row <= BOT_Y11 + SPR - 11'd1) &&
                     (col >= loc_x)   && (col <= loc_x + SPR - 11'd1);

    assign wall_hit = (col < SCR_W) &&
                      (((col >= wall_x) && (col <= wall_x + THICK - 11'd1)) ||
                       ((col >= wall_x + TUN_W) && (col <= wall_x + TUN_W + THICK - 11'd1)));

    always_comb begin
        loc_next = loc_x;
        if (go_left && !go_right)
            loc_next = (loc_x < STEP11) ? 11'd0 : loc_x - STEP11;
        else if (go_right && !go_left)
            loc_next = (loc_x + STEP11 > LOC_MAX) ? LOC_MAX : loc_x + STEP11;
    end

    always_comb begin
        wall_next = wall_x;
        case (game_info_reg[3:2])
            2'b01:   wall_next = (wall_x + DRIFT11 > WALL_MAX) ? WALL_MAX : wall_x + DRIFT11;
            2'b10:   wall_next = (wall_x < DRIFT11) ? 11'd0 : wall_x - DRIFT11;
            default: wall_next = wall_x;
        endcase
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            state  <= S_IDLE;
            loc_x  <= 11'(BOT_X0);
            wall_x <= 11'(WALL_X0);
        end else if (fs) begin
            case (state)
                S_IDLE: if (start) state <= S_PLAY;
                S_PLAY: begin
                    loc_x  <= loc_next;
                    wall_x <= wall_next;
                    if (crash_pending) state <= S_CRASH;
                end
                S_CRASH: if (!start) begin
                    state  <= S_IDLE;
                    loc_x  <= 11'(BOT_X0);
                    wall_x <= 11'(WALL_X0);
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef COLLISION_DETECT_EN
    logic play_hit;
    assign play_hit  = (state == S_PLAY) && bot_hit && wall_hit;
    assign collision = (state == S_CRASH);

    // A hit on the FS pixel itself belongs to the frame that FS opens
    always_ff @(posedge clock) begin
        if (rst)           crash_pending <= 1'b0;
        else if (fs)       crash_pending <= play_hit;
        else if (play_hit) crash_pending <= 1'b1;
    end

    always_ff @(posedge clock) begin
        if (rst)          icon <= 2'b00;
        else if (bot_hit) icon <= (state == S_CRASH) ? 2'b01 : 2'b11;
        else              icon <= 2'b00;
    end
`else
    assign crash_pending = 1'b0;
    assign collision     = 1'b0;

    always_ff @(posedge clock) begin
        if (rst) icon <= 2'b00;
        else     icon <= bot_hit ? 2'b11 : 2'b00;
    end
`endif

    always_ff @(posedge clock) begin
        if (rst) wall <= 2'b00;
        else     wall <= wall_hit ? 2'b10 : 2'b00;
    end

endmodule

// File: tb/tb_tunnel_game_renderer.sv
// Directed bench for tunnel_game_renderer; each "frame" is an FS cycle plus a few probe pixels.
// Expectations branch on COLLISION_DETECT_EN so both builds are checked.
module tb_tunnel_game_renderer;

    logic       clock = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] game_info_reg = 8'h00;
    logic [9:0] Pixel_row = 10'd0;
    logic [9:0] Pixel_column = 10'd0;
    logic [1:0] icon, wall, game_state;
    logic       collision;

    int n_cmp = 0;
    int n_err = 0;

    tunnel_game_renderer dut (
        .clock(clock), .rst(rst), .game_info_reg(game_info_reg),
        .Pixel_row(Pixel_row), .Pixel_column(Pixel_column),
        .icon(icon), .wall(wall), .collision(collision), .game_state(game_state)
    );

    always #20 clock = ~clock;

    // Present one pixel address; outputs for it are valid after return
    task automatic pix(input int r, input int c);
        @(negedge clock);
        Pixel_row    = 10'(r);
        Pixel_column = 10'(c);
        @(posedge clock);
        #1;
    endtask

    task automatic frames(input int n);
        for (int i = 0; i < n; i++) pix(0, 0);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        game_info_reg = 8'h80;
        pix(0, 0);
        pix(0, 0);
        if (game_state !== 2'b00) begin n_err++; $display("FAIL rst_fs_state got=%b exp=00", game_state); end n_cmp++;
        pix(256, 256);
        if (icon !== 2'b00) begin n_err++; $display("FAIL rst_icon got=%b exp=00", icon); end n_cmp++;
        pix(10, 192);
        if (wall !== 2'b00) begin n_err++; $display("FAIL rst_wall got=%b exp=00", wall); end n_cmp++;
        if (collision !== 1'b0) begin n_err++; $display("FAIL rst_collision got=%b exp=0", collision); end n_cmp++;
        rst = 1'b0;
        game_info_reg = 8'h00;
    endtask

    task automatic test_idle();
        game_info_reg = 8'h01;
        frames(3);
        if (game_state !== 2'b00) begin n_err++; $display("FAIL idle_state got=%b exp=00", game_state); end n_cmp++;
        pix(256, 256);
        if (icon !== 2'b11) begin n_err++; $display("FAIL idle_icon_tl got=%b exp=11", icon); end n_cmp++;
        pix(261, 261);
        if (icon !== 2'b11) begin n_err++; $display("FAIL idle_icon_br got=%b exp=11", icon); end n_cmp++;
        pix(255, 256);
        if (icon !== 2'b00) begin n_err++; $display("FAIL idle_icon_above got=%b exp=00", icon); end n_cmp++;
        pix(262, 256);
        if (icon !== 2'b00) begin n_err++; $display("FAIL idle_icon_below got=%b exp=00", icon); end n_cmp++;
        pix(256, 255);
        if (icon !== 2'b00) begin n_err++; $display("FAIL idle_icon_left got=%b exp=00", icon); end n_cmp++;
        pix(256, 262);
        if (icon !== 2'b00) begin n_err++; $display("FAIL idle_icon_right got=%b exp=00", icon); end n_cmp++;
        pix(10, 192);
        if (wall !== 2'b10) begin n_err++; $display("FAIL idle_wall_l got=%b exp=10", wall); end n_cmp++;
        pix(10, 193);
        if (wall !== 2'b00) begin n_err++; $display("FAIL idle_wall_gap got=%b exp=00", wall); end n_cmp++;
        pix(10, 320);
        if (wall !== 2'b10) begin n_err++; $display("FAIL idle_wall_r got=%b exp=10", wall); end n_cmp++;
        pix(10, 319);
        if (wall !== 2'b00) begin n_err++; $display("FAIL idle_wall_r_in got=%b exp=00", wall); end n_cmp++;
    endtask

    task automatic test_left();
        game_info_reg = 8'h81;
        frames(1);
        if (game_state !== 2'b01) begin n_err++; $display("FAIL left_state got=%b exp=01", game_state); end n_cmp++;
        pix(256, 256);
        if (icon !== 2'b11) begin n_err++; $display("FAIL left_nomove_on_start got=%b exp=11", icon); end n_cmp++;
        frames(10);
        pix(256, 246);
        if (icon !== 2'b11) begin n_err++; $display("FAIL left_246 got=%b exp=11", icon); end n_cmp++;
        pix(256, 245);
        if (icon !== 2'b00) begin n_err++; $display("FAIL left_245 got=%b exp=00", icon); end n_cmp++;
        pix(256, 252);
        if (icon !== 2'b00) begin n_err++; $display("FAIL left_252 got=%b exp=00", icon); end n_cmp++;
        frames(290);
        pix(256, 0);
        if (icon !== 2'b11) begin n_err++; $display("FAIL left_sat0 got=%b exp=11", icon); end n_cmp++;
        pix(256, 5);
        if (icon !== 2'b11) begin n_err++; $display("FAIL left_sat5 got=%b exp=11", icon); end n_cmp++;
        pix(256, 6);
        if (icon !== 2'b00) begin n_err++; $display("FAIL left_sat6 got=%b exp=00", icon); end n_cmp++;
        pix(256, 637);
        if (icon !== 2'b00) begin n_err++; $display("FAIL left_nowrap got=%b exp=00", icon); end n_cmp++;
        if (game_state !== 2'b01) begin n_err++; $display("FAIL left_state_end got=%b exp=01", game_state); end n_cmp++;
    endtask

    task automatic test_right_drift();
        game_info_reg = 8'h86;
        frames(700);
        pix(256, 634);
        if (icon !== 2'b11) begin n_err++; $display("FAIL right_634 got=%b exp=11", icon); end n_cmp++;
        pix(256, 638);
        if (icon !== 2'b11) begin n_err++; $display("FAIL right_638 got=%b exp=11", icon); end n_cmp++;
        pix(256, 633);
        if (icon !== 2'b00) begin n_err++; $display("FAIL right_633 got=%b exp=00", icon); end n_cmp++;
        pix(10, 511);
        if (wall !== 2'b10) begin n_err++; $display("FAIL drift_511 got=%b exp=10", wall); end n_cmp++;
        pix(10, 510);
        if (wall !== 2'b00) begin n_err++; $display("FAIL drift_510 got=%b exp=00", wall); end n_cmp++;
        pix(10, 639);
        if (wall !== 2'b10) begin n_err++; $display("FAIL drift_639 got=%b exp=10", wall); end n_cmp++;
        pix(10, 638);
        if (wall !== 2'b00) begin n_err++; $display("FAIL drift_638 got=%b exp=00", wall); end n_cmp++;
        pix(10, 640);
        if (wall !== 2'b00) begin n_err++; $display("FAIL offscreen_640 got=%b exp=00", wall); end n_cmp++;
        if (game_state !== 2'b01) begin n_err++; $display("FAIL right_state got=%b exp=01", game_state); end n_cmp++;
    endtask

    task automatic test_crash();
        game_info_reg = 8'h89;
        frames(261);
        pix(10, 250);
        if (wall !== 2'b10) begin n_err++; $display("FAIL crash_wall_250 got=%b exp=10", wall); end n_cmp++;
        pix(10, 249);
        if (wall !== 2'b00) begin n_err++; $display("FAIL crash_wall_249 got=%b exp=00", wall); end n_cmp++;
        pix(256, 373);
        if (icon !== 2'b11) begin n_err++; $display("FAIL crash_bot_373 got=%b exp=11", icon); end n_cmp++;
        game_info_reg = 8'h81;
        frames(123);
        pix(256, 249);
        if (icon !== 2'b00) begin n_err++; $display("FAIL crash_bot_249 got=%b exp=00", icon); end n_cmp++;
        pix(256, 250);
        if (icon !== 2'b11) begin n_err++; $display("FAIL crash_hit_icon got=%b exp=11", icon); end n_cmp++;
        if (game_state !== 2'b01) begin n_err++; $display("FAIL crash_state_midframe got=%b exp=01", game_state); end n_cmp++;
        game_info_reg = 8'h80;
        frames(1);
`ifdef COLLISION_DETECT_EN
        if (game_state !== 2'b10) begin n_err++; $display("FAIL crash_state got=%b exp=10", game_state); end n_cmp++;
        if (collision !== 1'b1) begin n_err++; $display("FAIL crash_collision got=%b exp=1", collision); end n_cmp++;
        pix(256, 250);
        if (icon !== 2'b01) begin n_err++; $display("FAIL crash_icon got=%b exp=01", icon); end n_cmp++;
        game_info_reg = 8'h81;
        frames(2);
        pix(256, 250);
        if (icon !== 2'b01) begin n_err++; $display("FAIL crash_frozen got=%b exp=01", icon); end n_cmp++;
        game_info_reg = 8'h80;
`else
        if (game_state !== 2'b01) begin n_err++; $display("FAIL nocd_state got=%b exp=01", game_state); end n_cmp++;
        if (collision !== 1'b0) begin n_err++; $display("FAIL nocd_collision got=%b exp=0", collision); end n_cmp++;
        pix(256, 250);
        if (icon !== 2'b11) begin n_err++; $display("FAIL nocd_icon got=%b exp=11", icon); end n_cmp++;
`endif
    endtask

    task automatic test_restart();
        game_info_reg = 8'h00;
        frames(1);
`ifdef COLLISION_DETECT_EN
        if (game_state !== 2'b00) begin n_err++; $display("FAIL restart_idle got=%b exp=00", game_state); end n_cmp++;
        if (collision !== 1'b0) begin n_err++; $display("FAIL restart_collision got=%b exp=0", collision); end n_cmp++;
        pix(256, 256);
        if (icon !== 2'b11) begin n_err++; $display("FAIL restart_locx got=%b exp=11", icon); end n_cmp++;
        pix(10, 192);
        if (wall !== 2'b10) begin n_err++; $display("FAIL restart_wallx got=%b exp=10", wall); end n_cmp++;
        game_info_reg = 8'h80;
        frames(1);
        if (game_state !== 2'b01) begin n_err++; $display("FAIL restart_play got=%b exp=01", game_state); end n_cmp++;
`else
        if (game_state !== 2'b01) begin n_err++; $display("FAIL nocd_play_hold got=%b exp=01", game_state); end n_cmp++;
`endif
    endtask

    task automatic test_reset_mid();
        int wcol;
`ifdef COLLISION_DETECT_EN
        game_info_reg = 8'h81;
        frames(64);
        pix(256, 192);
        game_info_reg = 8'h80;
        frames(1);
        if (game_state !== 2'b10) begin n_err++; $display("FAIL mid_crash_state got=%b exp=10", game_state); end n_cmp++;
        wcol = 192;
`else
        wcol = 250;
`endif
        rst = 1'b1;
        pix(100, wcol);
        if (wall !== 2'b00) begin n_err++; $display("FAIL mid_rst_wall got=%b exp=00", wall); end n_cmp++;
        if (icon !== 2'b00) begin n_err++; $display("FAIL mid_rst_icon got=%b exp=00", icon); end n_cmp++;
        if (collision !== 1'b0) begin n_err++; $display("FAIL mid_rst_collision got=%b exp=0", collision); end n_cmp++;
        if (game_state !== 2'b00) begin n_err++; $display("FAIL mid_rst_state got=%b exp=00", game_state); end n_cmp++;
        rst = 1'b0;
        game_info_reg = 8'h00;
        pix(256, 256);
        if (icon !== 2'b11) begin n_err++; $display("FAIL mid_rst_locx got=%b exp=11", icon); end n_cmp++;
        pix(10, 192);
        if (wall !== 2'b10) begin n_err++; $display("FAIL mid_rst_wallx got=%b exp=10", wall); end n_cmp++;
    endtask

    initial begin
        test_reset();
        test_idle();
        test_left();
        test_right_drift();
        test_crash();
        test_restart();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
